// File: rtl/irrigation_scheduler_if.sv
// Sensor/tick inputs and actuator/timer/state outputs of the irrigation scheduler.
// IRRIGATION_MANUAL_START_EN adds the start_pulse input.
interface irrigation_scheduler_if;
  logic       tick;
  logic       low_water_level;
  logic       mid_water_level;
  logic       high_water_level;
  logic       earth_humidity;
  logic       air_humidity;
  logic       low_temperature;
`ifdef IRRIGATION_MANUAL_START_EN
  logic       start_pulse;
`endif
  logic       splinker_bomb;
  logic       dripper_valvule;
  logic       water_supply_valvule;
  logic       alarm;
  logic [1:0] minutes_d;
  logic [3:0] minutes_u;
  logic [2:0] seconds_d;
  logic [2:0] state;

  modport master (
`ifdef IRRIGATION_MANUAL_START_EN
    output start_pulse,
`endif
    output tick, low_water_level, mid_water_level, high_water_level,
    output earth_humidity, air_humidity, low_temperature,
    input  splinker_bomb, dripper_valvule, water_supply_valvule, alarm,
    input  minutes_d, minutes_u, seconds_d, state
  );

  modport slave (
`ifdef IRRIGATION_MANUAL_START_EN
    input  start_pulse,
`endif
    input  tick, low_water_level, mid_water_level, high_water_level,
    input  earth_humidity, air_humidity, low_temperature,
    output splinker_bomb, dripper_valvule, water_supply_valvule, alarm,
    output minutes_d, minutes_u, seconds_d, state
  );
endinterface

// File: rtl/irrigation_scheduler.sv
// Tank-fill / irrigate / cooldown sequencer with a BCD countdown (one step per 10 s tick).
// IRRIGATION_MANUAL_START_EN: IDLE -> IRRIGATING also needs start_pulse.
//
// state      | meaning
// IDLE       | waiting; fill if tank low, irrigate if soil dry
// FILLING    | supply valve open until the tank is full
// IRRIGATING | sprinkler or dripper running, timer counting down
// COOLDOWN   | 50 s pause before returning to IDLE
// FAULT      | inconsistent level sensors; alarm until a clean tick
module irrigation_scheduler (
  input  logic                   clock,
  input  logic                   reset_n,
  irrigation_scheduler_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE       = 3'b000,
    FILLING    = 3'b001,
    IRRIGATING = 3'b010,
    COOLDOWN   = 3'b011,
    FAULT      = 3'b100
  } state_t;

  // timer layout: {minutes_d[1:0], minutes_u[3:0], seconds_d[2:0]}
  localparam logic [8:0] TIMER_ZERO  = 9'b00_0000_000;
  localparam logic [8:0] SPR_LOAD    = {2'd1, 4'd5, 3'd0};
  localparam logic [8:0] DRIP_LOAD   = {2'd3, 4'd0, 3'd0};
  localparam logic [8:0] COOL_LOAD   = {2'd0, 4'd0, 3'd5};

  state_t     state_q, state_d;
  logic [8:0] timer_q, timer_d;
  logic       mode_spr_q, mode_spr_d;
  logic       spr_q, spr_d;
  logic       drip_q, drip_d;
  logic       valve_q, valve_d;
  logic       alarm_q, alarm_d;

  logic conflict;
  logic timer_zero;
  logic start_ok;

  function automatic logic [8:0] bcd_dec(input logic [8:0] t);
    logic [1:0] md;
    logic [3:0] mu;
    logic [2:0] sd;
    {md, mu, sd} = t;
    if (t != TIMER_ZERO) begin
      if (sd != 3'd0) begin
        sd = sd - 3'd1;
      end else begin
        sd = 3'd5;
        if (mu != 4'd0) begin
          mu = mu - 4'd1;
        end else begin
          mu = 4'd9;
          md = md - 2'd1;
        end
      end
    end
    return {md, mu, sd};
  endfunction

  assign conflict   = (bus.high_water_level & ~bus.mid_water_level) |
                      (bus.mid_water_level  & ~bus.low_water_level);
  assign timer_zero = (timer_q == TIMER_ZERO);

`ifdef IRRIGATION_MANUAL_START_EN
  assign start_ok = bus.start_pulse;
`else
  assign start_ok = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    mode_spr_d = mode_spr_q;
    if (conflict) begin
      state_d = FAULT;
      timer_d = TIMER_ZERO;
    end else begin
      case (state_q)
        IDLE: begin
          timer_d = TIMER_ZERO;
          if (!bus.low_water_level) begin
            state_d = FILLING;
          end else if (!bus.earth_humidity && start_ok) begin
            state_d    = IRRIGATING;
            mode_spr_d = ~bus.air_humidity & ~bus.low_temperature & bus.mid_water_level;
            timer_d    = mode_spr_d ? SPR_LOAD : DRIP_LOAD;
          end
        end
        FILLING: begin
          timer_d = TIMER_ZERO;
          if (bus.high_water_level) state_d = IDLE;
        end
        IRRIGATING: begin
          // losing the tank outranks finishing the run
          if (!bus.low_water_level) begin
            state_d = FILLING;
            timer_d = TIMER_ZERO;
          end else if (bus.earth_humidity || (bus.tick && timer_zero)) begin
            state_d = COOLDOWN;
            timer_d = COOL_LOAD;
          end else if (bus.tick) begin
            timer_d = bcd_dec(timer_q);
          end
        end
        COOLDOWN: begin
          if (bus.tick && timer_zero) begin
            state_d = IDLE;
          end else if (bus.tick) begin
            timer_d = bcd_dec(timer_q);
          end
        end
        FAULT: begin
          timer_d = TIMER_ZERO;
          if (bus.tick) state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          timer_d = TIMER_ZERO;
        end
      endcase
    end

    spr_d   = (state_d == IRRIGATING) &&  mode_spr_d;
    drip_d  = (state_d == IRRIGATING) && !mode_spr_d;
    valve_d = (state_d == FILLING);
    alarm_d = (state_d == FAULT) || !bus.mid_water_level;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      timer_q    <= TIMER_ZERO;
      mode_spr_q <= 1'b0;
      spr_q      <= 1'b0;
      drip_q     <= 1'b0;
      valve_q    <= 1'b0;
      alarm_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      mode_spr_q <= mode_spr_d;
      spr_q      <= spr_d;
      drip_q     <= drip_d;
      valve_q    <= valve_d;
      alarm_q    <= alarm_d;
    end
  end

  assign bus.state                = state_q;
  assign bus.splinker_bomb        = spr_q;
  assign bus.dripper_valvule      = drip_q;
  assign bus.water_supply_valvule = valve_q;
  assign bus.alarm                = alarm_q;
  assign {bus.minutes_d, bus.minutes_u, bus.seconds_d} = timer_q;

endmodule

// File: tb/tb_irrigation_scheduler.sv
// Directed scenarios plus randomized traffic, checked against a behavioural model
// that tracks the remaining time as a plain count of 10 s ticks.
module tb_irrigation_scheduler;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  irrigation_scheduler_if bus ();
  irrigation_scheduler dut (.clock(clock), .reset_n(reset_n), .bus(bus));

  int checks = 0;
  int failures = 0;

  // model: 0 idle, 1 filling, 2 irrigating, 3 cooldown, 4 fault
  int m_st = 0;
  int m_t = 0;
  bit m_spr_mode = 0;
  bit m_spr = 0, m_drip = 0, m_valve = 0, m_alarm = 0;
  bit start_v = 1;

  task automatic model_update();
    bit lo, mid, hi, conflict;
    lo = bus.low_water_level; mid = bus.mid_water_level; hi = bus.high_water_level;
    conflict = (hi && !mid) || (mid && !lo);
    if (!reset_n) begin
      m_st = 0; m_t = 0; m_spr_mode = 0;
      m_spr = 0; m_drip = 0; m_valve = 0; m_alarm = 0;
      return;
    end
    if (conflict) begin
      m_st = 4; m_t = 0;
    end else if (m_st == 0) begin
      if (!lo) m_st = 1;
      else if (!bus.earth_humidity && start_v) begin
        m_st = 2;
        m_spr_mode = !bus.air_humidity && !bus.low_temperature && mid;
        m_t = m_spr_mode ? 90 : 180;   // 15 min / 30 min in 10 s ticks
      end
    end else if (m_st == 1) begin
      if (hi) m_st = 0;
    end else if (m_st == 2) begin
      if (!lo) begin m_st = 1; m_t = 0; end
      else if (bus.earth_humidity || (bus.tick && m_t == 0)) begin m_st = 3; m_t = 5; end
      else if (bus.tick) m_t = m_t - 1;
    end else if (m_st == 3) begin
      if (bus.tick && m_t == 0) m_st = 0;
      else if (bus.tick) m_t = m_t - 1;
    end else begin
      if (bus.tick) m_st = 0;
    end
    m_spr   = (m_st == 2) && m_spr_mode;
    m_drip  = (m_st == 2) && !m_spr_mode;
    m_valve = (m_st == 1);
    m_alarm = (m_st == 4) || !mid;
  endtask

  task automatic check_model(input string tag);
    int mins;
    logic [8:0] exp_t;
    logic [3:0] exp_o;
    mins  = m_t / 6;
    exp_t = {2'(mins / 10), 4'(mins % 10), 3'(m_t % 6)};
    exp_o = {m_spr, m_drip, m_valve, m_alarm};
    checks++;
    assert (bus.state === 3'(m_st)) else begin
      failures++;
      $error("FAIL %s state: got %0d want %0d", tag, bus.state, m_st);
    end
    checks++;
    assert ({bus.splinker_bomb, bus.dripper_valvule, bus.water_supply_valvule, bus.alarm} === exp_o) else begin
      failures++;
      $error("FAIL %s outputs{spr,drip,valve,alarm}: got %b want %b", tag,
             {bus.splinker_bomb, bus.dripper_valvule, bus.water_supply_valvule, bus.alarm}, exp_o);
    end
    checks++;
    assert ({bus.minutes_d, bus.minutes_u, bus.seconds_d} === exp_t) else begin
      failures++;
      $error("FAIL %s timer: got %0d%0d:%0d0 want %0d%0d:%0d0", tag,
             bus.minutes_d, bus.minutes_u, bus.seconds_d, exp_t[8:7], exp_t[6:3], exp_t[2:0]);
    end
  endtask

  task automatic expect_val(input string tag, input logic [8:0] got, input logic [8:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  task automatic step(input logic tk, input string tag);
    bus.tick = tk;
    @(posedge clock);
    model_update();
    #1;
    check_model(tag);
  endtask

  task automatic set_levels(input bit lo, input bit mid, input bit hi);
    bus.low_water_level = lo; bus.mid_water_level = mid; bus.high_water_level = hi;
  endtask

  function automatic logic [8:0] tmr();
    return {bus.minutes_d, bus.minutes_u, bus.seconds_d};
  endfunction

  initial begin
    bus.tick = 0;
    set_levels(1, 1, 1);
    bus.earth_humidity = 0; bus.air_humidity = 0; bus.low_temperature = 0;
`ifdef IRRIGATION_MANUAL_START_EN
    bus.start_pulse = 1;
`endif

    // reset, then sprinkler run
    reset_n = 0;
    step(0, "reset");
    step(1, "reset");
    expect_val("reset_state", 9'(bus.state), 9'd0);
    expect_val("reset_timer", tmr(), 9'd0);
    reset_n = 1;
    step(0, "spr_start");
    expect_val("spr_state", 9'(bus.state), 9'd2);
    expect_val("spr_bomb", 9'(bus.splinker_bomb), 9'd1);
    expect_val("spr_load", tmr(), {2'd1, 4'd5, 3'd0});
    repeat (90) step(1, "spr_run");
    expect_val("spr_at_zero", tmr(), 9'd0);
    step(1, "spr_end");
    expect_val("cool_state", 9'(bus.state), 9'd3);
    expect_val("cool_load", tmr(), {2'd0, 4'd0, 3'd5});

    // dripper run once cooldown expires
    bus.air_humidity = 1;
    repeat (6) step(1, "cool_run");
    expect_val("cool_to_idle", 9'(bus.state), 9'd0);
    step(0, "drip_start");
    expect_val("drip_valve", 9'(bus.dripper_valvule), 9'd1);
    expect_val("drip_load", tmr(), {2'd3, 4'd0, 3'd0});
    step(1, "drip_tick");
    expect_val("drip_borrow", tmr(), {2'd2, 4'd9, 3'd5});
    repeat (178) step(1, "drip_run");
    expect_val("drip_at_one", tmr(), {2'd0, 4'd0, 3'd1});
    bus.earth_humidity = 1;
    step(1, "humid_and_tick");
    expect_val("humid_tick_state", 9'(bus.state), 9'd3);
    expect_val("humid_tick_timer", tmr(), {2'd0, 4'd0, 3'd5});
    bus.earth_humidity = 0;

    // filling
    set_levels(0, 0, 0);
    repeat (6) step(1, "cool_run2");
    step(0, "fill_start");
    expect_val("fill_state", 9'(bus.state), 9'd1);
    expect_val("fill_valve", 9'(bus.water_supply_valvule), 9'd1);
    step(0, "fill_hold");
    set_levels(1, 1, 1);
    step(0, "fill_done");
    expect_val("fill_exit", 9'(bus.state), 9'd0);
    expect_val("fill_valve_off", 9'(bus.water_supply_valvule), 9'd0);

    // sensor conflict during irrigation
    step(0, "irr_again");
    set_levels(1, 0, 1);
    step(0, "fault_enter");
    expect_val("fault_state", 9'(bus.state), 9'd4);
    expect_val("fault_alarm", 9'(bus.alarm), 9'd1);
    expect_val("fault_valves", 9'({bus.splinker_bomb, bus.dripper_valvule}), 9'd0);
    step(1, "fault_hold");
    set_levels(1, 1, 1);
    step(0, "fault_no_tick");
    step(1, "fault_exit");
    expect_val("fault_to_idle", 9'(bus.state), 9'd0);

    // reset during irrigation, with a conflict present
    step(0, "irr_pre_reset");
    step(1, "irr_pre_reset");
    reset_n = 0;
    set_levels(1, 0, 1);
    step(1, "reset_irr");
    expect_val("reset_irr_state", 9'(bus.state), 9'd0);
    expect_val("reset_irr_outs", 9'({bus.splinker_bomb, bus.dripper_valvule,
                                    bus.water_supply_valvule, bus.alarm}), 9'd0);
    expect_val("reset_irr_timer", tmr(), 9'd0);
    reset_n = 1;
    set_levels(1, 1, 1);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = $urandom_range(0, 3);
      if ($urandom_range(0, 19) == 0)
        set_levels(1'($urandom), 1'($urandom), 1'($urandom));
      else if ($urandom_range(0, 7) == 0)
        set_levels(r >= 1, r >= 2, r >= 3);
      bus.earth_humidity  = ($urandom_range(0, 15) == 0);
      bus.air_humidity    = 1'($urandom);
      bus.low_temperature = 1'($urandom);
      reset_n = ($urandom_range(0, 299) != 0);
`ifdef IRRIGATION_MANUAL_START_EN
      bus.start_pulse = 1'($urandom);
      start_v = bus.start_pulse;
`endif
      step(($urandom_range(0, 2) == 0), "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
